// File: rtl/mux_rr_nch_pkg.sv
// Shared constants and helpers for the round-robin mux/demux family.
package mux_pkg;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_DATA_W = 8;

    // Elaboration-time ceil(log2(n)) for blocks that need it as a plain function.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int DEF_CH_W = clog2_f(DEF_N_CH);

    // Grant pointer advance with wrap, shared with the demux side.
    function automatic int next_ptr(input int g, input int n);
        return (g >= n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mux_rr_nch_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after ptr
// wins, wrapping to the lowest index when nothing at or above ptr is requesting.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  N_CH = DEF_N_CH,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any_req
);

    logic [N_CH-1:0] hi_mask;
    logic [N_CH-1:0] masked_req;
    logic [N_CH-1:0] sel_req;
    logic            found;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_mask
            assign hi_mask[gi] = (CH_W'(gi) >= ptr);
        end
    endgenerate

    assign any_req    = |req;
    assign masked_req = req & hi_mask;
    // Nothing pending at or above ptr means the search has wrapped past N_CH-1.
    assign sel_req    = (|masked_req) ? masked_req : req;

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && sel_req[k]) begin
                found   = 1'b1;
                gnt_idx = CH_W'(k);
            end
        end
    end

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_gnt
            assign gnt[gi] = en && any_req && (gnt_idx == CH_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/mux_rr_nch.sv
// N-channel round-robin arbitrating mux with valid/ready on every port and a
// registered output stage. Define MUX_CH_ID_EN to add the ch_out source-channel port.
module mux_rr_nch
    import mux_pkg::*;
#(
    parameter int  N_CH   = DEF_N_CH,
    parameter int  DATA_W = DEF_DATA_W,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        valid_in,
    input  logic [N_CH*DATA_W-1:0] data_in,
    output logic [N_CH-1:0]        ready_out,
    output logic [DATA_W-1:0]      data_out,
    output logic                   valid_out,
    input  logic                   ready_in
`ifdef MUX_CH_ID_EN
    ,
    output logic [CH_W-1:0]        ch_out
`endif
);

    logic              valid_out_q;
    logic [DATA_W-1:0] data_out_q;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   ptr_d;

    logic              load;
    logic              arb_en;
    logic              any_req;
    logic              accept;
    logic [N_CH-1:0]   gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic [DATA_W-1:0] ch_data [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_data[gi] = data_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Output register can take a new word when empty or being drained this cycle.
    assign load   = !valid_out_q || ready_in;
    assign arb_en = load && !reset;
    assign accept = arb_en && any_req;

    rr_arbiter #(
        .N_CH    (N_CH)
    ) u_arb (
        .req     (valid_in),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign ready_out = gnt;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = CH_W'(next_ptr(int'(gnt_idx), N_CH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load) begin
                valid_out_q <= any_req;
                if (any_req) begin
                    data_out_q <= ch_data[gnt_idx];
                end
            end
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

`ifdef MUX_CH_ID_EN
    logic [CH_W-1:0] ch_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_out_q <= '0;
        end else if (accept) begin
            ch_out_q <= gnt_idx;
        end
    end

    assign ch_out = ch_out_q;
`endif

endmodule

// File: tb/tb_mux_rr_nch.sv
// Directed bench for mux_rr_nch (N_CH=4, DATA_W=8) with a behavioural round-robin
// reference model checked every cycle, plus hand-computed expectations per scenario.
module tb_mux_rr_nch;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    valid_in;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    ready_out;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic            ready_in;
    logic [1:0]      ch_out;

    int checks;
    int errors;

    mux_rr_nch #(
        .N_CH      (N),
        .DATA_W    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
`ifdef MUX_CH_ID_EN
        ,
        .ch_out    (ch_out)
`endif
    );

`ifndef MUX_CH_ID_EN
    assign ch_out = 2'b00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_ptr;
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_ch;
    logic        started;

    initial started = 1'b0;

    function automatic int winner(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ch    = 0;
            m_ptr   = 0;
            started = 1'b1;
        end else if (started && (!m_valid || ready_in)) begin
            w = winner(m_ptr, valid_in);
            if (w >= 0) begin
                m_data  = data_in[w*DW +: DW];
                m_valid = 1'b1;
                m_ch    = w;
                m_ptr   = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int w;
        if (started) begin
            exp_rdy = '0;
            w = winner(m_ptr, valid_in);
            if (!reset && (!m_valid || ready_in) && w >= 0) exp_rdy[w] = 1'b1;
            checks++;
            if (valid_out !== m_valid) begin
                errors++;
                $display("FAIL model_valid_out t=%0t got %b want %b", $time, valid_out, m_valid);
            end
            checks++;
            if (data_out !== m_data) begin
                errors++;
                $display("FAIL model_data_out t=%0t got %h want %h", $time, data_out, m_data);
            end
            checks++;
            if (ready_out !== exp_rdy) begin
                errors++;
                $display("FAIL model_ready_out t=%0t got %b want %b", $time, ready_out, exp_rdy);
            end
`ifdef MUX_CH_ID_EN
            checks++;
            if (ch_out !== 2'(m_ch)) begin
                errors++;
                $display("FAIL model_ch_out t=%0t got %0d want %0d", $time, ch_out, m_ch);
            end
`endif
            if (valid_out && ready_in)
                $display("xfer t=%0t data=%h ch=%0d", $time, data_out, ch_out);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic r, input logic [N-1:0] v, input logic rdy);
        @(posedge clk);
        #1;
        reset    = r;
        valid_in = v;
        ready_in = rdy;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [7:0] d,
                           input logic [1:0] c, input logic [3:0] rdy);
        chk({name, "_valid"}, 32'(valid_out), 32'(v));
        if (v || name == "rst") chk({name, "_data"}, 32'(data_out), 32'(d));
`ifdef MUX_CH_ID_EN
        if (v || name == "rst") chk({name, "_ch"}, 32'(ch_out), 32'(c));
`endif
        chk({name, "_ready"}, 32'(ready_out), 32'(rdy));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        valid_in = 4'b1111;
        ready_in = 1'b1;
        data_in  = 32'hD3C2B1A0;

        // 1: reset held two edges with every channel valid
        cyc(1, 4'b1111, 1);
        cyc(1, 4'b1111, 1);
        chk_out("rst", 0, 8'h00, 2'd0, 4'b0000);
        cyc(0, 4'b1111, 1);
        chk_out("rel", 0, 8'h00, 2'd0, 4'b0001);

        // 2: full rotation
        cyc(0, 4'b1111, 1); chk_out("rr0", 1, 8'hA0, 2'd0, 4'b0010);
        cyc(0, 4'b1111, 1); chk_out("rr1", 1, 8'hB1, 2'd1, 4'b0100);
        cyc(0, 4'b1111, 1); chk_out("rr2", 1, 8'hC2, 2'd2, 4'b1000);
        cyc(0, 4'b1111, 1); chk_out("rr3", 1, 8'hD3, 2'd3, 4'b0001);
        cyc(0, 4'b1111, 1); chk_out("rr4", 1, 8'hA0, 2'd0, 4'b0010);

        // 3: only ch2, then ch1+ch3 with ptr at 3
        data_in = 32'hD35AB1A0;
        cyc(0, 4'b0100, 1); chk_out("solo_b", 1, 8'hB1, 2'd1, 4'b0100);
        cyc(0, 4'b0100, 1); chk_out("solo0", 1, 8'h5A, 2'd2, 4'b0100);
        cyc(0, 4'b0100, 1); chk_out("solo1", 1, 8'h5A, 2'd2, 4'b0100);
        cyc(0, 4'b0100, 1); chk_out("solo2", 1, 8'h5A, 2'd2, 4'b0100);
        cyc(0, 4'b1010, 1); chk_out("pick3", 1, 8'h5A, 2'd2, 4'b1000);
        cyc(0, 4'b1010, 1); chk_out("got3", 1, 8'hD3, 2'd3, 4'b0010);
        cyc(0, 4'b1010, 1); chk_out("got1", 1, 8'hB1, 2'd1, 4'b1000);

        // 4: stall with everything valid, then resume at ptr
        data_in = 32'hD3C2B1A0;
        cyc(0, 4'b1111, 0); chk_out("stall0", 1, 8'hD3, 2'd3, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 4'b1111, 0); chk_out("stall", 1, 8'hD3, 2'd3, 4'b0000);
        end
        cyc(0, 4'b1111, 1); chk_out("resume", 1, 8'hD3, 2'd3, 4'b0001);
        cyc(0, 4'b1111, 1); chk_out("resume_a", 1, 8'hA0, 2'd0, 4'b0010);

        // 5: reset while a word is stalled in the output register
        cyc(0, 4'b1111, 0); chk_out("hold_b", 1, 8'hB1, 2'd1, 4'b0000);
        cyc(0, 4'b1111, 0); chk_out("hold_b2", 1, 8'hB1, 2'd1, 4'b0000);
        cyc(1, 4'b1111, 0); chk_out("rst_in", 1, 8'hB1, 2'd1, 4'b0000);
        cyc(0, 4'b1111, 0); chk_out("rst", 0, 8'h00, 2'd0, 4'b0001);
        cyc(0, 4'b1111, 1); chk_out("post_rst", 1, 8'hA0, 2'd0, 4'b0010);

        // idle input: valid drops, data/ch hold
        cyc(0, 4'b0000, 1); chk_out("last_b", 1, 8'hB1, 2'd1, 4'b0000);
        cyc(0, 4'b0000, 1);
        chk("idle_valid", 32'(valid_out), 32'd0);
        chk("idle_data", 32'(data_out), 32'hB1);
`ifdef MUX_CH_ID_EN
        chk("idle_ch", 32'(ch_out), 32'd1);
`endif
        cyc(0, 4'b0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
